// File: rtl/ntsc_pkg.sv
// Shared types and constants for the NTSC scanline buffer and video path.
package ntsc_pkg;

  localparam int PIXEL_W     = 2;
  localparam int LINE_ADDR_W = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam pixel_t PIX_BLACK = 2'b00;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } lb_state_t;

  // Pixel 0 is the leftmost pixel and sits in the least significant bits.
  function automatic pixel_t lane_pick(input logic [7:0] packed_byte, input logic [1:0] lane);
    pixel_t pix;
    case (lane)
      2'd0:    pix = packed_byte[1:0];
      2'd1:    pix = packed_byte[3:2];
      2'd2:    pix = packed_byte[5:4];
      default: pix = packed_byte[7:6];
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/ntsc_linebuf_bank.sv
// One scanline bank: simple dual-port RAM, synchronous write and synchronous read.
module ntsc_linebuf_bank #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or read register; the top level masks stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ntsc_line_buffer.sv
// Ping-pong scanline buffer feeding the video generator; host fills the back bank.
// Build option NTSC_LINEBUF_UNDERRUN_BLANK_EN blanks the line after an underrun.
//
// state | meaning
// FILL  | back bank accepting bytes, wr_ready high
// FULL  | back bank complete, waiting for line_start to swap
module ntsc_line_buffer
  import ntsc_pkg::*;
#(
  parameter int LINE_PIXELS    = 512,
  parameter int BYTES_PER_LINE = LINE_PIXELS / 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_data,
  input  logic                   line_start,
  input  logic [LINE_ADDR_W-1:0] rd_addr,
  output pixel_t                 rd_pixel,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  lb_state_t  state_q;
  logic [7:0] wr_ptr_q;
  logic       front_sel_q;
  logic       front_valid_q;
  logic       underrun_q;
  logic       blank_q;

  logic       wr_accept;
  logic       last_byte;
  logic       bank_full;
  logic       swap;
  logic       miss;
  logic       in_range;

  logic       we0;
  logic       we1;
  logic [7:0] rd_data0;
  logic [7:0] rd_data1;

  logic       rd_bank_q;
  logic [1:0] rd_lane_q;
  logic       rd_show_q;

  assign wr_ready  = (state_q == FILL);
  assign wr_accept = wr_valid && wr_ready;
  assign last_byte = wr_accept && (wr_ptr_q == 8'(BYTES_PER_LINE - 1));
  // A byte landing on the line_start edge still completes the bank in time.
  assign bank_full = (state_q == FULL) || last_byte;
  assign swap      = line_start && bank_full;
  assign miss      = line_start && !bank_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
    end else if (swap) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      front_sel_q   <= !front_sel_q;
      front_valid_q <= 1'b1;
    end else if (wr_accept) begin
      wr_ptr_q <= wr_ptr_q + 8'd1;
      if (last_byte) begin
        state_q <= FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_q <= 1'b0;
    end else if (miss) begin
      underrun_q <= 1'b1;
    end else if (underrun_clr) begin
      underrun_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;

`ifdef NTSC_LINEBUF_UNDERRUN_BLANK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= 1'b0;
    end else if (swap) begin
      blank_q <= 1'b0;
    end else if (miss) begin
      blank_q <= 1'b1;
    end
  end
`else
  assign blank_q = 1'b0;
`endif

  // The write bank is always the one not being displayed.
  assign we0 = wr_accept && front_sel_q;
  assign we1 = wr_accept && !front_sel_q;

  ntsc_linebuf_bank #(
    .DEPTH  (128),
    .ADDR_W (7),
    .DATA_W (8)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (we0),
    .wr_addr (wr_ptr_q[6:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr[8:2]),
    .rd_data (rd_data0)
  );

  ntsc_linebuf_bank #(
    .DEPTH  (128),
    .ADDR_W (7),
    .DATA_W (8)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (we1),
    .wr_addr (wr_ptr_q[6:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr[8:2]),
    .rd_data (rd_data1)
  );

  assign in_range = ({1'b0, rd_addr} < 10'(LINE_PIXELS));

  // Lane, bank and visibility are captured alongside the RAM read so they line up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank_q <= 1'b0;
      rd_lane_q <= 2'd0;
      rd_show_q <= 1'b0;
    end else begin
      rd_bank_q <= front_sel_q;
      rd_lane_q <= rd_addr[1:0];
      rd_show_q <= front_valid_q && !blank_q && in_range;
    end
  end

  always_comb begin
    rd_pixel = PIX_BLACK;
    if (rd_show_q) begin
      rd_pixel = lane_pick(rd_bank_q ? rd_data1 : rd_data0, rd_lane_q);
    end
  end

endmodule
